// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte-length message arriving as 32-bit words into
// 512-bit blocks, appends the 0x80 marker and the 64-bit bit-length, handing blocks downstream.
module sha256_msg_padder #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [511:0]     blk_data,
    output logic             blk_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, LENBLK} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      buf_reg [16];
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] words_left_reg;
    logic [3:0]       slot_reg;
    logic             last_reg;
    logic             pad_placed_reg;
    logic             done_reg;

    logic             accept;
    logic             final_word;
    logic [1:0]       tail;
    logic             pad_in_word;
    logic             pad_now;
    logic             len_fits;
    logic [63:0]      len_bits;
    logic [LEN_W:0]   words_total;
    logic [31:0]      word_stored;

    assign accept      = (state_reg == FILL) && in_valid;
    assign final_word  = (words_left_reg == LEN_W'(1));
    assign tail        = len_reg[1:0];
    assign pad_in_word = (tail != 2'd0);
    // 0x80 lands either inside the final data word or in the slot after it, if one is left
    assign pad_now     = pad_in_word || (slot_reg != 4'd15);
    assign len_fits    = (len_reg[5:0] <= 6'd55);
    assign len_bits    = 64'({len_reg, 3'b000});
    assign words_total = ({1'b0, msg_len} + (LEN_W+1)'(3)) >> 2;

    always_comb begin
        word_stored = in_data;
        if (final_word) begin
            case (tail)
                2'd1:    word_stored = {in_data[31:24], 24'h800000};
                2'd2:    word_stored = {in_data[31:16], 16'h8000};
                2'd3:    word_stored = {in_data[31:8],  8'h80};
                default: word_stored = in_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (msg_len == '0) ? LENBLK : FILL;
                end
            end
            FILL: begin
                if (accept && (final_word || slot_reg == 4'd15)) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    if (last_reg) begin
                        state_next = IDLE;
                    end else if (words_left_reg != '0) begin
                        state_next = FILL;
                    end else begin
                        state_next = LENBLK;
                    end
                end
            end
            LENBLK: state_next = EMIT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == FILL);
        blk_valid = (state_reg == EMIT);
        blk_last  = (state_reg == EMIT) && last_reg;
        busy      = (state_reg != IDLE);
        done      = done_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) buf_reg[i] <= '0;
            len_reg        <= '0;
            words_left_reg <= '0;
            slot_reg       <= '0;
            last_reg       <= 1'b0;
            pad_placed_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) buf_reg[i] <= '0;
                        len_reg        <= msg_len;
                        words_left_reg <= words_total[LEN_W-1:0];
                        slot_reg       <= '0;
                        last_reg       <= 1'b0;
                        pad_placed_reg <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        buf_reg[slot_reg] <= word_stored;
                        words_left_reg    <= words_left_reg - LEN_W'(1);
                        slot_reg          <= slot_reg + 4'd1;
                        if (final_word && pad_now) begin
                            pad_placed_reg <= 1'b1;
                            if (!pad_in_word) begin
                                buf_reg[slot_reg + 4'd1] <= 32'h8000_0000;
                            end
                            if (len_fits) begin
                                buf_reg[14] <= len_bits[63:32];
                                buf_reg[15] <= len_bits[31:0];
                                last_reg    <= 1'b1;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        for (int i = 0; i < 16; i++) buf_reg[i] <= '0;
                        slot_reg <= '0;
                        if (last_reg) begin
                            done_reg <= 1'b1;
                            last_reg <= 1'b0;
                        end
                    end
                end
                LENBLK: begin
                    // Trailing block: carries the marker too when the data ended on a block boundary
                    if (!pad_placed_reg) begin
                        buf_reg[0] <= 32'h8000_0000;
                    end
                    buf_reg[14]    <= len_bits[63:32];
                    buf_reg[15]    <= len_bits[31:0];
                    last_reg       <= 1'b1;
                    pad_placed_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pack
            assign blk_data[511-32*gi -: 32] = buf_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: a byte-level SHA-256 padding model builds the expected blocks,
// driven by a vector table, random messages and a mid-message reset sequence.
module tb_sha256_msg_padder;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             blk_valid;
    logic             blk_ready;
    logic [511:0]     blk_data;
    logic             blk_last;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .msg_len   (msg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int len;
        int stall;
        bit fixed;
        bit fast;
        int exp_blocks;
    } vec_t;

    int           errors = 0;
    int           checks = 0;
    logic [511:0] got_q[$];
    int           hs_cyc[$];
    bit           saw_in_ready;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [511:0] b, input int i);
        return b[511-32*i -: 32];
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_blk_valid"}, blk_valid, 0);
        chk({tag, "_blk_last"},  blk_last,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_blk_data"},  blk_data,  0);
    endtask

    task automatic run_msg(input int len, input int stall, input bit fixed, input bit fast);
        logic [7:0]   msg[$];
        logic [7:0]   pad[$];
        logic [7:0]   abc[3];
        logic [31:0]  words[$];
        logic [511:0] exp_blk[$];
        logic [511:0] blk, prev_data;
        logic [63:0]  lbits;
        logic [31:0]  w;
        logic [7:0]   b;
        logic         prev_last;
        int nwords, widx, bidx, cyc, stall_left;
        bit held, exp_done;

        abc = '{8'h61, 8'h62, 8'h63};
        for (int i = 0; i < len; i++) msg.push_back(fixed ? abc[i % 3] : 8'($urandom));
        // Standard SHA-256 padding on the byte stream
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        lbits = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(lbits[8*k +: 8]);
        for (int k = 0; k < pad.size() / 64; k++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk = {blk[503:0], pad[64*k + j]};
            exp_blk.push_back(blk);
        end
        nwords = (len + 3) / 4;
        for (int i = 0; i < nwords; i++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                b = (4*i + j < len) ? msg[4*i + j] : (fixed ? 8'hFF : 8'($urandom));
                w = {w[23:0], b};
            end
            words.push_back(w);
        end

        got_q.delete();
        hs_cyc.delete();
        saw_in_ready = 0;
        @(negedge clk);
        start = 1'b1; msg_len = LEN_W'(len); in_valid = 1'b0; blk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        widx = 0; bidx = 0; cyc = 0; held = 0; exp_done = 0; stall_left = stall;
        prev_data = '0; prev_last = 1'b0;
        while (1) begin
            chk("done_pulse", done, exp_done);
            if (exp_done) begin
                chk("idle_after_done", busy, 0);
                break;
            end
            cyc++;
            if (cyc > 4000) begin
                chk("timeout_blocks_seen", bidx, exp_blk.size());
                break;
            end
            if (in_ready) saw_in_ready = 1;
            if (widx >= nwords) chk("in_ready_after_data", in_ready, 0);
            if (held) begin
                chk("hold_data", blk_data, prev_data);
                chk("hold_last", blk_last, prev_last);
                chk("hold_in_ready", in_ready, 0);
            end
            in_valid = (widx < nwords) && (fast || ($urandom % 4 != 0));
            in_data  = in_valid ? words[widx] : $urandom;
            if (in_valid && in_ready) widx++;
            if (blk_valid && bidx == 0 && stall_left > 0) begin
                blk_ready = 1'b0;
                stall_left--;
            end else begin
                blk_ready = fast || ($urandom % 3 != 0);
            end
            start   = busy && ($urandom % 8 == 0);
            msg_len = LEN_W'($urandom);
            held      = blk_valid && !blk_ready;
            prev_data = blk_data;
            prev_last = blk_last;
            if (blk_valid && blk_ready) begin
                if (bidx < exp_blk.size()) begin
                    chk($sformatf("blk%0d_data", bidx), blk_data, exp_blk[bidx]);
                    chk($sformatf("blk%0d_last", bidx), blk_last, (bidx == exp_blk.size() - 1));
                end else begin
                    chk("extra_block", bidx, exp_blk.size() - 1);
                end
                got_q.push_back(blk_data);
                hs_cyc.push_back(cyc);
                bidx++;
                exp_done = (bidx == exp_blk.size());
            end
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; blk_ready = 1'b0;
        chk("words_accepted", widx, nwords);
        chk("block_count_model", bidx, exp_blk.size());
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{len: 3,   stall: 0,  fixed: 1, fast: 0, exp_blocks: 1};
        vecs[1]  = '{len: 80,  stall: 0,  fixed: 0, fast: 0, exp_blocks: 2};
        vecs[2]  = '{len: 56,  stall: 0,  fixed: 0, fast: 0, exp_blocks: 2};
        vecs[3]  = '{len: 0,   stall: 0,  fixed: 0, fast: 0, exp_blocks: 1};
        vecs[4]  = '{len: 64,  stall: 10, fixed: 0, fast: 0, exp_blocks: 2};
        vecs[5]  = '{len: 55,  stall: 0,  fixed: 0, fast: 0, exp_blocks: 1};
        vecs[6]  = '{len: 57,  stall: 3,  fixed: 0, fast: 0, exp_blocks: 2};
        vecs[7]  = '{len: 63,  stall: 0,  fixed: 0, fast: 0, exp_blocks: 2};
        vecs[8]  = '{len: 128, stall: 0,  fixed: 0, fast: 1, exp_blocks: 3};
        vecs[9]  = '{len: 1,   stall: 0,  fixed: 0, fast: 0, exp_blocks: 1};
        vecs[10] = '{len: 4,   stall: 0,  fixed: 0, fast: 0, exp_blocks: 1};
        vecs[11] = '{len: 119, stall: 0,  fixed: 0, fast: 0, exp_blocks: 2};
        vecs[12] = '{len: 120, stall: 2,  fixed: 0, fast: 0, exp_blocks: 3};

        rst_n = 1'b0; start = 1'b0; msg_len = '0; in_valid = 1'b0; in_data = '0; blk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            run_msg(vecs[v].len, vecs[v].stall, vecs[v].fixed, vecs[v].fast);
            chk($sformatf("len%0d_nblocks", vecs[v].len), got_q.size(), vecs[v].exp_blocks);
            $display("vector len=%0d stall=%0d blocks=%0d errors=%0d",
                     vecs[v].len, vecs[v].stall, got_q.size(), errors);
            if (got_q.size() == vecs[v].exp_blocks) begin
                if (vecs[v].fixed) begin
                    chk("abc_word0",  wd(got_q[0], 0),  32'h6162_6380);
                    chk("abc_word15", wd(got_q[0], 15), 32'h0000_0018);
                end
                if (vecs[v].len == 56) begin
                    chk("len56_b0_word14", wd(got_q[0], 14), 32'h8000_0000);
                    chk("len56_b0_word15", wd(got_q[0], 15), 32'h0);
                    chk("len56_b1",        got_q[1], 512'h1C0);
                end
                if (vecs[v].len == 0) begin
                    chk("len0_block",    got_q[0], {32'h8000_0000, 480'h0});
                    chk("len0_no_ready", saw_in_ready, 0);
                end
                if (vecs[v].len == 64) begin
                    chk("len64_b1_word0",  wd(got_q[1], 0),  32'h8000_0000);
                    chk("len64_b1_word15", wd(got_q[1], 15), 32'h0000_0200);
                end
                if (vecs[v].len == 80) begin
                    chk("len80_b1_word4",  wd(got_q[1], 4),  32'h8000_0000);
                    chk("len80_b1_word15", wd(got_q[1], 15), 32'h0000_0280);
                end
                if (vecs[v].fast) chk("throughput_17", hs_cyc[1] - hs_cyc[0], 17);
            end
        end

        for (int r = 0; r < 8; r++) begin
            int len, stall;
            len   = $urandom_range(0, 300);
            stall = $urandom_range(0, 3);
            run_msg(len, stall, 0, 0);
            $display("random len=%0d stall=%0d blocks=%0d errors=%0d", len, stall, got_q.size(), errors);
        end

        // Reset part-way through a 20-word message, then a clean short message
        @(negedge clk);
        start = 1'b1; msg_len = LEN_W'(80);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = $urandom;
            @(negedge clk);
        end
        chk("midmsg_busy", busy, 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midmsg_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_no_done", done, 0);
        run_msg(3, 0, 1, 0);
        chk("post_reset_nblocks", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("post_reset_block", got_q[0], {32'h6162_6380, 448'h0, 32'h0000_0018});
        end
        $display("reset sequence errors=%0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
